atm_account_arbiter: RTL and testbench
======================================

Name: atm_account_arbiter

Overview:
- Shares the single account table (account no / PIN / balance, 4 entries) among NREQ ATM front-end controllers.
- Round-robin grants one request at a time.
- Each transaction (lookup, PIN check, balance arithmetic, write-back) executes atomically, so concurrent terminals cannot corrupt balances.
- A transfer debits the source and credits the destination in the same cycle.

Parameters:
- NREQ, 2, number of requesting terminals (2..4)
- NACCT, 4, number of account-table entries
- AW, 17, account-number and PIN width
- BW, 19, balance and amount width
- MAX_FAILS, 3, consecutive wrong PINs that lock an account

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, per requester
- req_ready  out  NREQ  grant; one-cycle pulse to the accepted requester
- req_op  in  NREQ*3  opcode per requester
- req_acct  in  NREQ*AW  own account number
- req_pin  in  NREQ*AW  entered PIN
- req_dst  in  NREQ*AW  transfer destination account
- req_amount  in  NREQ*BW  withdraw, deposit or transfer amount
- req_new_pin  in  NREQ*AW  new PIN for change-PIN
- rsp_valid  out  NREQ  one-cycle response pulse to the owning requester
- rsp_status  out  3  result code, valid with rsp_valid
- rsp_balance  out  BW  source balance after the operation, valid with rsp_valid
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_status=0, rsp_balance=0, busy=0.
  - rr_ptr=0; all fail counters 0; all locks clear.
  - Table loads the package init values: (C5AA,1F5E,5000), (705C,04BF,8000), (3219,04D2,7500), (8629,0D05,3000).
- Opcodes: 001 balance, 010 withdraw, 011 deposit, 100 transfer, 101 change PIN. 000, 110 and 111 are invalid.
- Status codes: 0 OK, 1 BAD_ACCT, 2 BAD_PIN, 3 LOCKED, 4 INSUFF, 5 BAD_DST, 6 BAD_OP, 7 OVERFLOW.
- Arbitration in IDLE:
  - Scan req_valid starting at rr_ptr, wrapping.
  - The first asserted requester i gets req_ready[i]=1 for that cycle; its fields are captured in the same cycle.
  - Then rr_ptr=(i+1) mod NREQ.
  - No valid requests: remain in IDLE, rr_ptr unchanged.
- FSM IDLE -> LOOKUP -> EXEC -> RESP -> IDLE.
  - Latency: acceptance at cycle 0, rsp_valid at cycle 3.
  - Minimum spacing between grants: 4 cycles.
- LOOKUP:
  - Parallel compare of captured acct and dst against all entries; registers hit flags and indices.
  - Duplicate account numbers are illegal configuration; lowest index wins.
- EXEC checks, in priority order (first failing check sets the status; the table is untouched on any failure):
  1. src miss -> BAD_ACCT.
  2. src locked -> LOCKED. The PIN is not evaluated and the fail counter is unchanged.
  3. PIN mismatch -> BAD_PIN.
     - Fail counter increments.
     - On reaching MAX_FAILS the lock bit sets.
     - This request still returns BAD_PIN; later requests return LOCKED.
  4. Correct PIN: fail counter clears, then:
     - invalid opcode -> BAD_OP.
     - withdraw with amount > balance -> INSUFF. Amount == balance is OK and leaves balance 0.
     - deposit with balance+amount > 2^BW-1 -> OVERFLOW. Use a BW+1-bit sum.
     - transfer with dst miss, or dst index == src index -> BAD_DST.
     - transfer with amount > src balance -> INSUFF.
     - transfer with dst balance+amount overflowing -> OVERFLOW. Neither entry is changed.
     - change PIN: writes new PIN. Checked last so a bad-op path never writes.
- Write-back:
  - A successful transfer writes both balances in the single EXEC cycle (table has two write ports).
  - Amount 0 is legal and returns OK with balances unchanged.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle.
  - rsp_balance is the source entry's post-operation balance; 0 when status is BAD_ACCT.
- Requester rules:
  - Requesters must hold their fields stable while req_valid is high until req_ready.
  - Deasserting req_valid before grant withdraws the request with no response.
- Reset asserted mid-transaction: the transaction is aborted, no response is issued, and the table reinitialises.
- Locks clear only on reset.

Decomposition:
- Package atm_pkg holds:
  - opcode and status localparams;
  - AW/BW defaults;
  - init account/PIN/balance constants for the 4 entries;
  - MAX_FAILS.
- Sub-module atm_account_table holds:
  - storage registers, fail counters and lock bits;
  - dual parallel lookup comparators;
  - two balance write ports plus a PIN write port.
- atm_account_arbiter contains the round-robin arbiter, FSM, checks and arithmetic.

Test Plan:
- Requester 0, acct C5AA, PIN 1F5E, withdraw 5000 -> status 0, balance 0. A repeat withdraw of 1 -> status 4, balance 0.
- Requester 1, acct 705C, PIN 04BF, transfer 500 to 3219 -> status 0, balance 7500. A following balance query on 3219 (PIN 04D2) -> balance 8000.
- Three requests on 8629 with PIN 0000 -> BAD_PIN, BAD_PIN, BAD_PIN. A fourth request with correct PIN 0D05 -> LOCKED, balance 3000 unchanged.
- Both requesters valid in the same cycle after reset:
  - requester 0 is granted first; requester 1 is granted exactly 4 cycles later;
  - req_ready is never high for both requesters together.
- Edge cases, acct 3219 (PIN 04D2):
  - deposit 2^19-1 -> OVERFLOW, balance 7500;
  - transfer to itself -> BAD_DST;
  - opcode 111 -> BAD_OP;
  - acct 1111 -> BAD_ACCT, balance 0.
- Reset driven low at cycle 2 of a withdraw on C5AA -> no rsp_valid, and balance reads 5000 after reset.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared constants for the ATM account arbiter: opcodes, status codes,
// default widths and the power-up contents of the account table.
package atm_pkg;

  localparam int AW_DEF    = 17;
  localparam int BW_DEF    = 19;
  localparam int NACCT_DEF = 4;
  localparam int MAX_FAILS = 3;

  localparam logic [2:0] OP_BAL  = 3'd1;
  localparam logic [2:0] OP_WDR  = 3'd2;
  localparam logic [2:0] OP_DEP  = 3'd3;
  localparam logic [2:0] OP_XFR  = 3'd4;
  localparam logic [2:0] OP_PIN  = 3'd5;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD_ACCT = 3'd1;
  localparam logic [2:0] ST_BAD_PIN  = 3'd2;
  localparam logic [2:0] ST_LOCKED   = 3'd3;
  localparam logic [2:0] ST_INSUFF   = 3'd4;
  localparam logic [2:0] ST_BAD_DST  = 3'd5;
  localparam logic [2:0] ST_BAD_OP   = 3'd6;
  localparam logic [2:0] ST_OVERFLOW = 3'd7;

  function automatic logic [31:0] init_acct(input int i);
    case (i)
      0: return 32'h0C5AA;
      1: return 32'h0705C;
      2: return 32'h03219;
      3: return 32'h08629;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] init_pin(input int i);
    case (i)
      0: return 32'h01F5E;
      1: return 32'h004BF;
      2: return 32'h004D2;
      3: return 32'h00D05;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] init_bal(input int i);
    case (i)
      0: return 32'd5000;
      1: return 32'd8000;
      2: return 32'd7500;
      3: return 32'd3000;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/atm_account_table.sv
// Account storage with fail counters, lock bits, two parallel lookups,
// two balance write ports and one PIN write port.
module atm_account_table
  import atm_pkg::*;
#(
  parameter int NACCT     = NACCT_DEF,
  parameter int AW        = AW_DEF,
  parameter int BW        = BW_DEF,
  parameter int MAX_FAILS = atm_pkg::MAX_FAILS,
  parameter int IW        = (NACCT > 1) ? $clog2(NACCT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] look_a,
  input  logic [AW-1:0] look_b,
  output logic          hit_a,
  output logic [IW-1:0] idx_a,
  output logic          hit_b,
  output logic [IW-1:0] idx_b,
  input  logic [IW-1:0] rd_idx_a,
  input  logic [IW-1:0] rd_idx_b,
  output logic [AW-1:0] rd_pin_a,
  output logic [BW-1:0] rd_bal_a,
  output logic          rd_lock_a,
  output logic [BW-1:0] rd_bal_b,
  input  logic          wa_en,
  input  logic [IW-1:0] wa_idx,
  input  logic [BW-1:0] wa_bal,
  input  logic          wb_en,
  input  logic [IW-1:0] wb_idx,
  input  logic [BW-1:0] wb_bal,
  input  logic          pin_we,
  input  logic [IW-1:0] pin_idx,
  input  logic [AW-1:0] pin_val,
  input  logic          fail_inc,
  input  logic          fail_clr,
  input  logic [IW-1:0] fail_idx
);

  localparam int FW = $clog2(MAX_FAILS + 1);

  logic [AW-1:0] acct [NACCT];
  logic [AW-1:0] pin  [NACCT];
  logic [BW-1:0] bal  [NACCT];
  logic [FW-1:0] fails[NACCT];
  logic          lock [NACCT];

  // Scan downwards so the lowest matching index wins on duplicates.
  always_comb begin
    hit_a = 1'b0;
    idx_a = '0;
    hit_b = 1'b0;
    idx_b = '0;
    for (int i = NACCT - 1; i >= 0; i--) begin
      if (acct[i] == look_a) begin
        hit_a = 1'b1;
        idx_a = IW'(i);
      end
      if (acct[i] == look_b) begin
        hit_b = 1'b1;
        idx_b = IW'(i);
      end
    end
  end

  assign rd_pin_a  = pin[rd_idx_a];
  assign rd_bal_a  = bal[rd_idx_a];
  assign rd_lock_a = lock[rd_idx_a];
  assign rd_bal_b  = bal[rd_idx_b];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NACCT; i++) begin
        acct[i]  <= AW'(init_acct(i));
        pin[i]   <= AW'(init_pin(i));
        bal[i]   <= BW'(init_bal(i));
        fails[i] <= '0;
        lock[i]  <= 1'b0;
      end
    end else begin
      if (wa_en) bal[wa_idx] <= wa_bal;
      if (wb_en) bal[wb_idx] <= wb_bal;
      if (pin_we) pin[pin_idx] <= pin_val;
      if (fail_clr) begin
        fails[fail_idx] <= '0;
      end else if (fail_inc) begin
        fails[fail_idx] <= fails[fail_idx] + 1'b1;
        if (fails[fail_idx] == FW'(MAX_FAILS - 1))
          lock[fail_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter and atomic transaction FSM in front of the
// shared ATM account table.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int NACCT     = NACCT_DEF,
  parameter int AW        = AW_DEF,
  parameter int BW        = BW_DEF,
  parameter int MAX_FAILS = atm_pkg::MAX_FAILS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*3-1:0] req_op,
  input  logic [NREQ*AW-1:0] req_acct,
  input  logic [NREQ*AW-1:0] req_pin,
  input  logic [NREQ*AW-1:0] req_dst,
  input  logic [NREQ*BW-1:0] req_amount,
  input  logic [NREQ*AW-1:0] req_new_pin,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2:0]        rsp_status,
  output logic [BW-1:0]     rsp_balance,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (NACCT > 1) ? $clog2(NACCT) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_LOOKUP, S_EXEC, S_RESP
  } state_t;

  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] acct;
    logic [AW-1:0] pin;
    logic [AW-1:0] dst;
    logic [BW-1:0] amt;
    logic [AW-1:0] npin;
  } txn_t;

  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, owner, gnt_idx;
  logic gnt_any;
  txn_t txn;

  logic hit_a, hit_b, hit_a_q, hit_b_q;
  logic [IW-1:0] idx_a, idx_b, idx_a_q, idx_b_q;
  logic [AW-1:0] rd_pin_a;
  logic [BW-1:0] rd_bal_a, rd_bal_b;
  logic rd_lock_a;

  logic [2:0] ex_st, st_q;
  logic [BW-1:0] ex_bal, bal_q, wa_bal, wb_bal;
  logic [BW:0] dep_sum, dst_sum;
  logic wa_en, wb_en, pin_we, fail_inc, fail_clr, in_exec;

  always_comb begin
    int j;
    j = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[owner] = 1'b1;
  end

  assign busy        = (state != S_IDLE);
  assign rsp_status  = st_q;
  assign rsp_balance = bal_q;
  assign in_exec     = (state == S_EXEC);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (gnt_any) state_nx = S_LOOKUP;
      S_LOOKUP: state_nx = S_EXEC;
      S_EXEC:   state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      txn     <= '0;
      hit_a_q <= 1'b0;
      hit_b_q <= 1'b0;
      idx_a_q <= '0;
      idx_b_q <= '0;
      st_q    <= '0;
      bal_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && gnt_any) begin
        owner    <= gnt_idx;
        rr_ptr   <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        txn.op   <= req_op[gnt_idx*3 +: 3];
        txn.acct <= req_acct[gnt_idx*AW +: AW];
        txn.pin  <= req_pin[gnt_idx*AW +: AW];
        txn.dst  <= req_dst[gnt_idx*AW +: AW];
        txn.amt  <= req_amount[gnt_idx*BW +: BW];
        txn.npin <= req_new_pin[gnt_idx*AW +: AW];
      end
      if (state == S_LOOKUP) begin
        hit_a_q <= hit_a;
        hit_b_q <= hit_b;
        idx_a_q <= idx_a;
        idx_b_q <= idx_b;
      end
      if (in_exec) begin
        st_q  <= ex_st;
        bal_q <= ex_bal;
      end
    end
  end

  // Checks run in priority order; any failure leaves the table untouched.
  always_comb begin
    ex_st    = ST_OK;
    ex_bal   = rd_bal_a;
    wa_en    = 1'b0;
    wa_bal   = rd_bal_a;
    wb_en    = 1'b0;
    wb_bal   = rd_bal_b;
    pin_we   = 1'b0;
    fail_inc = 1'b0;
    fail_clr = 1'b0;
    dep_sum  = {1'b0, rd_bal_a} + {1'b0, txn.amt};
    dst_sum  = {1'b0, rd_bal_b} + {1'b0, txn.amt};
    if (!hit_a_q) begin
      ex_st  = ST_BAD_ACCT;
      ex_bal = '0;
    end else if (rd_lock_a) begin
      ex_st = ST_LOCKED;
    end else if (rd_pin_a != txn.pin) begin
      ex_st    = ST_BAD_PIN;
      fail_inc = 1'b1;
    end else begin
      fail_clr = 1'b1;
      case (txn.op)
        OP_BAL: ex_st = ST_OK;
        OP_WDR: begin
          if (txn.amt > rd_bal_a) begin
            ex_st = ST_INSUFF;
          end else begin
            wa_en  = 1'b1;
            wa_bal = rd_bal_a - txn.amt;
            ex_bal = wa_bal;
          end
        end
        OP_DEP: begin
          if (dep_sum[BW]) begin
            ex_st = ST_OVERFLOW;
          end else begin
            wa_en  = 1'b1;
            wa_bal = dep_sum[BW-1:0];
            ex_bal = wa_bal;
          end
        end
        OP_XFR: begin
          if (!hit_b_q || idx_b_q == idx_a_q) begin
            ex_st = ST_BAD_DST;
          end else if (txn.amt > rd_bal_a) begin
            ex_st = ST_INSUFF;
          end else if (dst_sum[BW]) begin
            ex_st = ST_OVERFLOW;
          end else begin
            wa_en  = 1'b1;
            wa_bal = rd_bal_a - txn.amt;
            wb_en  = 1'b1;
            wb_bal = dst_sum[BW-1:0];
            ex_bal = wa_bal;
          end
        end
        OP_PIN: pin_we = 1'b1;
        default: ex_st = ST_BAD_OP;
      endcase
    end
  end

  atm_account_table #(
    .NACCT(NACCT), .AW(AW), .BW(BW),
    .MAX_FAILS(MAX_FAILS), .IW(IW)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .look_a    (txn.acct),
    .look_b    (txn.dst),
    .hit_a     (hit_a),
    .idx_a     (idx_a),
    .hit_b     (hit_b),
    .idx_b     (idx_b),
    .rd_idx_a  (idx_a_q),
    .rd_idx_b  (idx_b_q),
    .rd_pin_a  (rd_pin_a),
    .rd_bal_a  (rd_bal_a),
    .rd_lock_a (rd_lock_a),
    .rd_bal_b  (rd_bal_b),
    .wa_en     (wa_en && in_exec),
    .wa_idx    (idx_a_q),
    .wa_bal    (wa_bal),
    .wb_en     (wb_en && in_exec),
    .wb_idx    (idx_b_q),
    .wb_bal    (wb_bal),
    .pin_we    (pin_we && in_exec),
    .pin_idx   (idx_a_q),
    .pin_val   (txn.npin),
    .fail_inc  (fail_inc && in_exec),
    .fail_clr  (fail_clr && in_exec),
    .fail_idx  (idx_a_q)
  );

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Scoreboard bench for atm_account_arbiter: directed transactions push
// expected responses, a negedge monitor pops and compares them.
module tb_atm_account_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 17;
  localparam int BW   = 19;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*3-1:0] req_op = '0;
  logic [NREQ*AW-1:0] req_acct = '0;
  logic [NREQ*AW-1:0] req_pin = '0;
  logic [NREQ*AW-1:0] req_dst = '0;
  logic [NREQ*BW-1:0] req_amount = '0;
  logic [NREQ*AW-1:0] req_new_pin = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [2:0]        rsp_status;
  logic [BW-1:0]     rsp_balance;
  logic              busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  logic [21:0] q0[$];
  logic [21:0] q1[$];

  atm_account_arbiter #(.NREQ(NREQ), .NACCT(4), .AW(AW), .BW(BW), .MAX_FAILS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_acct    (req_acct),
    .req_pin     (req_pin),
    .req_dst     (req_dst),
    .req_amount  (req_amount),
    .req_new_pin (req_new_pin),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_balance (rsp_balance),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [21:0] e;
    e = '0;
    if (reset) begin
      if (|req_ready) begin
        total++;
        if (req_ready[0] && req_ready[1]) begin
          bad++;
          $display("FAIL ready_onehot got=%b want at most one", req_ready);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          rsp_cnt++;
          total++;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_rsp req=%0d st=%0d bal=%0d", i, rsp_status, rsp_balance);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            if ({rsp_status, rsp_balance} !== e) begin
              bad++;
              $display("FAIL rsp_req%0d got st=%0d bal=%0d want st=%0d bal=%0d",
                       i, rsp_status, rsp_balance, e[21:19], e[18:0]);
            end
          end
        end
      end
    end
  end

  task automatic issue(input int r, input logic [2:0] op, input logic [16:0] acct,
                       input logic [16:0] pin, input logic [16:0] dst,
                       input logic [18:0] amt, input logic [16:0] npin,
                       input logic [2:0] est, input logic [18:0] ebal,
                       input bit exp_rsp, output int gcyc);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    gcyc = -1;
    req_op[r*3 +: 3]       = op;
    req_acct[r*AW +: AW]   = acct;
    req_pin[r*AW +: AW]    = pin;
    req_dst[r*AW +: AW]    = dst;
    req_amount[r*BW +: BW] = amt;
    req_new_pin[r*AW +: AW] = npin;
    req_valid[r] = 1'b1;
    while (!got && n < 40) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
      else n++;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL grant_timeout req=%0d got=none want=grant", r);
    end else begin
      gcyc = cyc;
      if (exp_rsp) begin
        if (r == 0) q0.push_back({est, ebal});
        else q1.push_back({est, ebal});
      end
    end
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout pending=%0d want=0", q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int r, input logic [2:0] op, input logic [16:0] acct,
                    input logic [16:0] pin, input logic [16:0] dst,
                    input logic [18:0] amt, input logic [2:0] est,
                    input logic [18:0] ebal);
    int g;
    issue(r, op, acct, pin, dst, amt, 17'h0, est, ebal, 1'b1, g);
    drain();
  endtask

  initial begin
    int g0, g1;
    g0 = 0;
    g1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, req_ready, rsp_valid, rsp_status, rsp_balance} !== '0) begin
      bad++;
      $display("FAIL reset_state got busy=%b rdy=%b vld=%b st=%0d bal=%0d want all 0",
               busy, req_ready, rsp_valid, rsp_status, rsp_balance);
    end
    @(posedge clk);
    #1;

    fork
      issue(0, 3'd1, 17'hC5AA, 17'h1F5E, 17'h0, 19'd0, 17'h0, 3'd0, 19'd5000, 1'b1, g0);
      issue(1, 3'd1, 17'h705C, 17'h04BF, 17'h0, 19'd0, 17'h0, 3'd0, 19'd8000, 1'b1, g1);
    join
    drain();
    total++;
    if (g1 - g0 != 4 || g0 < 0) begin
      bad++;
      $display("FAIL grant_spacing got r0=%0d r1=%0d want r1-r0=4", g0, g1);
    end

    go(1, 3'd3, 17'h3219, 17'h04D2, 17'h0,    19'd524287, 3'd7, 19'd7500);
    go(1, 3'd4, 17'h3219, 17'h04D2, 17'h3219, 19'd1,      3'd5, 19'd7500);
    go(1, 3'd7, 17'h3219, 17'h04D2, 17'h0,    19'd1,      3'd6, 19'd7500);
    go(0, 3'd1, 17'h1111, 17'h04D2, 17'h0,    19'd0,      3'd1, 19'd0);

    go(0, 3'd2, 17'hC5AA, 17'h1F5E, 17'h0, 19'd5000, 3'd0, 19'd0);
    go(0, 3'd2, 17'hC5AA, 17'h1F5E, 17'h0, 19'd1,    3'd4, 19'd0);

    go(1, 3'd4, 17'h705C, 17'h04BF, 17'h3219, 19'd500, 3'd0, 19'd7500);
    go(1, 3'd1, 17'h3219, 17'h04D2, 17'h0,    19'd0,   3'd0, 19'd8000);

    issue(0, 3'd5, 17'h3219, 17'h04D2, 17'h0, 19'd0, 17'h0ABC, 3'd0, 19'd8000, 1'b1, g0);
    drain();
    go(0, 3'd1, 17'h3219, 17'h04D2, 17'h0, 19'd0, 3'd2, 19'd8000);
    go(0, 3'd1, 17'h3219, 17'h0ABC, 17'h0, 19'd0, 3'd0, 19'd8000);

    for (int k = 0; k < 3; k++)
      go(0, 3'd1, 17'h8629, 17'h0000, 17'h0, 19'd0, 3'd2, 19'd3000);
    go(0, 3'd1, 17'h8629, 17'h0D05, 17'h0, 19'd0, 3'd3, 19'd3000);

    issue(0, 3'd2, 17'hC5AA, 17'h1F5E, 17'h0, 19'd0, 17'h0, 3'd0, 19'd0, 1'b0, g0);
    @(posedge clk);
    #1 reset = 1'b0;
    rsp_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (rsp_cnt != 0) begin
      bad++;
      $display("FAIL abort_no_rsp got=%0d want=0", rsp_cnt);
    end
    @(posedge clk);
    #1;
    go(0, 3'd1, 17'hC5AA, 17'h1F5E, 17'h0, 19'd0, 3'd0, 19'd5000);
    go(1, 3'd1, 17'h8629, 17'h0D05, 17'h0, 19'd0, 3'd0, 19'd3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck want=finish");
    $fatal(1);
  end

endmodule
